// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Multiplexed 8-digit seven-segment display driver for the vending machine
//   front panel. Takes hex digits, blank and decimal-point masks, and scans
//   them one digit at a time onto a shared anode/segment bus.
//   New values go into a pending buffer and reach the display only at a frame
//   boundary. Because of this, a partial update is never visible.
//
//   Optional feature: define SEG_BLINK_EN to enable per-digit blinking. With
//   it enabled, a frame counter toggles a blink phase every BLINK_DIV frames.
//   While that phase is high, digits selected by i_blink are dark.
module seg_scan_display #(
    parameter int SCAN_DIV  = 100000,  // i_clk cycles per digit slot, >= 2
    parameter int BLINK_DIV = 250      // frames per blink phase (SEG_BLINK_EN)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [31:0] i_digits,
    input  logic [7:0]  i_blank,
    input  logic [7:0]  i_dp,
    input  logic [7:0]  i_blink,
    output logic [7:0]  o_an,
    output logic [6:0]  o_seg,
    output logic        o_dp,
    output logic        o_load_ack,
    output logic        o_frame
);

    localparam int            PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    // ------------------------------------------------------------------
    // Scan timing state
    // ------------------------------------------------------------------
    logic [PW-1:0] r_presc;
    logic [2:0]    r_idx;
    logic          w_tick;
    logic          w_wrap;

    // ------------------------------------------------------------------
    // Double-buffered display contents
    // ------------------------------------------------------------------
    logic [31:0] r_act_digits;
    logic [7:0]  r_act_blank;
    logic [7:0]  r_act_dp;
    logic [31:0] r_pend_digits;
    logic [7:0]  r_pend_blank;
    logic [7:0]  r_pend_dp;
    logic        r_pend_valid;

    // ------------------------------------------------------------------
    // Output stage registers and the current-slot decode
    // ------------------------------------------------------------------
    logic [7:0] r_an;
    logic [6:0] r_seg;
    logic       r_dp;
    logic       r_load_ack;
    logic       r_frame;

    logic [3:0] w_digit_val;
    logic [6:0] w_seg_dec;
    logic       w_blink_dark;
    logic       w_blanked;

    assign w_tick = (r_presc == PRESC_MAX);
    assign w_wrap = w_tick && (r_idx == 3'd7);

    // Prescaler: counts 0..SCAN_DIV-1, and each wrap is one digit slot
    always_ff @(posedge i_clk) begin
        // NOTE: reset is synchronous, so it is checked inside the clocked
        //       branch rather than being listed in the sensitivity list.
        if (i_rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments. This way
            //       every block sees the pre-edge values in the same cycle.
            r_presc <= r_presc + 1'b1;
        end
    end

    // Digit index: advances once per slot and wraps 7 -> 0 naturally
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx <= 3'd0;
        end else if (w_tick) begin
            r_idx <= r_idx + 3'd1;
        end
    end

    // Pending buffer: any i_load overwrites it, and the latest load wins
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend_digits <= '0;
            r_pend_blank  <= '0;
            r_pend_dp     <= '0;
        end else if (i_load) begin
            r_pend_digits <= i_digits;
            r_pend_blank  <= i_blank;
            r_pend_dp     <= i_dp;
        end
    end

    // Pending-valid flag: set by a load and cleared when a wrap applies it.
    // A load in the wrap cycle itself keeps the flag set for the next frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend_valid <= 1'b0;
        end else if (i_load) begin
            r_pend_valid <= 1'b1;
        end else if (w_wrap) begin
            r_pend_valid <= 1'b0;
        end
    end

    // Active buffer: takes the old pending contents only at a frame boundary
    always_ff @(posedge i_clk) begin
        // NOTE: the display buffers are ordinary flops, not a RAM. Resetting
        //       them gives a defined dark display after reset.
        if (i_rst) begin
            r_act_digits <= '0;
            r_act_blank  <= 8'hFF;
            r_act_dp     <= '0;
        end else if (w_wrap && r_pend_valid) begin
            r_act_digits <= r_pend_digits;
            r_act_blank  <= r_pend_blank;
            r_act_dp     <= r_pend_dp;
        end
    end

    // Frame and load-acknowledge pulses, one cycle after the wrap
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame    <= 1'b0;
            r_load_ack <= 1'b0;
        end else begin
            r_frame    <= w_wrap;
            r_load_ack <= w_wrap && r_pend_valid;
        end
    end

`ifdef SEG_BLINK_EN
    localparam int            BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    logic [BW-1:0] r_frame_cnt;
    logic          r_blink_phase;

    // Blink timing: count frames and flip the phase every BLINK_DIV frames
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_wrap) begin
            if (r_frame_cnt == BLINK_MAX) begin
                r_frame_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame_cnt   <= r_frame_cnt + 1'b1;
            end
        end
    end

    // i_blink is used live, without buffering; only the phase is registered
    assign w_blink_dark = r_blink_phase & i_blink[r_idx];
`else
    // Without blinking, the blink input and its parameter have no effect
    logic w_unused_blink;
    assign w_unused_blink = ^{i_blink, BLINK_DIV[0]};
    assign w_blink_dark   = 1'b0;
`endif

    assign w_digit_val = r_act_digits[{r_idx, 2'b00} +: 4];
    assign w_blanked   = r_act_blank[r_idx] | w_blink_dark;

    // Hex to seven-segment decode, with bit order {g,f,e,d,c,b,a}
    always_comb begin
        // NOTE: a default before the case statement keeps this block purely
        //       combinational, so no latch is inferred.
        w_seg_dec = 7'h00;
        case (w_digit_val)
            4'h0: w_seg_dec = 7'h3F;
            4'h1: w_seg_dec = 7'h06;
            4'h2: w_seg_dec = 7'h5B;
            4'h3: w_seg_dec = 7'h4F;
            4'h4: w_seg_dec = 7'h66;
            4'h5: w_seg_dec = 7'h6D;
            4'h6: w_seg_dec = 7'h7D;
            4'h7: w_seg_dec = 7'h07;
            4'h8: w_seg_dec = 7'h7F;
            4'h9: w_seg_dec = 7'h6F;
            4'hA: w_seg_dec = 7'h77;
            4'hB: w_seg_dec = 7'h7C;
            4'hC: w_seg_dec = 7'h39;
            4'hD: w_seg_dec = 7'h5E;
            4'hE: w_seg_dec = 7'h79;
            4'hF: w_seg_dec = 7'h71;
            default: w_seg_dec = 7'h00;
        endcase
    end

    // Registered output stage: follows the digit index with one cycle of lag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_an  <= '0;
            r_seg <= '0;
            r_dp  <= 1'b0;
        end else begin
            r_an  <= w_blanked ? 8'h00 : (8'h01 << r_idx);
            r_seg <= w_blanked ? 7'h00 : w_seg_dec;
            r_dp  <= r_act_dp[r_idx] & ~w_blanked;
        end
    end

    assign o_an       = r_an;
    assign o_seg      = r_seg;
    assign o_dp       = r_dp;
    assign o_load_ack = r_load_ack;
    assign o_frame    = r_frame;

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display
//   Directed and randomized stimulus for seg_scan_display with SCAN_DIV=4 and
//   BLINK_DIV=2. Every cycle is compared against a frame-level reference
//   model, which derives the slot from the cycle count since reset. Directed
//   checks cover acks, frame pulses, blanking and reset behaviour.
//   SEG_BLINK_EN is honoured by the model when the macro is defined.
module tb_seg_scan_display;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 2;
    localparam int FRAME     = 8 * SCAN_DIV;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        i_rst, i_load;
    logic [31:0] i_digits;
    logic [7:0]  i_blank, i_dp, i_blink;
    logic [7:0]  o_an;
    logic [6:0]  o_seg;
    logic        o_dp, o_load_ack, o_frame;

    seg_scan_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_load(i_load), .i_digits(i_digits),
        .i_blank(i_blank), .i_dp(i_dp), .i_blink(i_blink),
        .o_an(o_an), .o_seg(o_seg), .o_dp(o_dp),
        .o_load_ack(o_load_ack), .o_frame(o_frame)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: cycles since reset, plus both buffers
    int unsigned m_c, m_wraps;
    logic [31:0] m_act_d, m_pend_d;
    logic [7:0]  m_act_b, m_act_dp, m_pend_b, m_pend_dp;
    bit          m_pv;
    logic [17:0] m_exp;   // {an, seg, dp, ack, frame}

    // Observation counters used by the directed checks
    int n_ack, n_frame, n_lit, n_hi;
    logic [6:0] seen_seg [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model across one clock edge, using the inputs the DUT sees
    task automatic model_edge();
        int  idx;
        bit  wrap, blanked;
        logic [7:0] an;
        logic [6:0] seg;
        if (i_rst) begin
            m_c = 0; m_wraps = 0; m_pv = 0;
            m_act_d = '0; m_act_b = 8'hFF; m_act_dp = '0;
            m_pend_d = '0; m_pend_b = '0; m_pend_dp = '0;
            m_exp = '0;
            return;
        end
        idx     = int'((m_c / SCAN_DIV) % 8);
        wrap    = (m_c % FRAME) == FRAME - 1;
        blanked = m_act_b[idx];
`ifdef SEG_BLINK_EN
        if (((m_wraps / BLINK_DIV) % 2) == 1 && i_blink[idx]) blanked = 1;
`endif
        an  = blanked ? 8'h00 : 8'(1 << idx);
        seg = blanked ? 7'h00 : SEG_TAB[m_act_d[idx*4 +: 4]];
        m_exp = {an, seg, m_act_dp[idx] & ~blanked, wrap & m_pv, wrap};
        if (wrap && m_pv) begin
            m_act_d = m_pend_d; m_act_b = m_pend_b; m_act_dp = m_pend_dp;
            m_pv = 0;
        end
        if (wrap) m_wraps++;
        if (i_load) begin
            m_pend_d = i_digits; m_pend_b = i_blank; m_pend_dp = i_dp;
            m_pv = 1;
        end
        m_c++;
    endtask

    // One clock: update the model at the edge, then compare at the falling edge
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check($sformatf("outputs@c%0d", m_c),
              {14'd0, o_an, o_seg, o_dp, o_load_ack, o_frame}, {14'd0, m_exp});
        n_ack   += int'(o_load_ack);
        n_frame += int'(o_frame);
        n_lit   += int'(o_an != 8'h00);
        n_hi    += int'(o_an[7:4] != 4'h0);
        for (int k = 0; k < 8; k++)
            if (o_an == 8'(1 << k)) seen_seg[k] = o_seg;
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] b, input logic [7:0] dp);
        i_load = 1'b1; i_digits = d; i_blank = b; i_dp = dp;
        step();
        i_load = 1'b0;
    endtask

    task automatic to_frame_start();
        for (int i = 0; i < FRAME && (m_c % FRAME) != 0; i++) step();
    endtask

    int a0, f0;

    initial begin
        i_rst = 1'b1; i_load = 1'b0; i_digits = '0; i_blank = '0; i_dp = '0;
        i_blink = '0;
        n_ack = 0; n_frame = 0; n_lit = 0; n_hi = 0;
        for (int k = 0; k < 8; k++) seen_seg[k] = '0;
        m_c = 0; m_wraps = 0; m_pv = 0; m_exp = '0;
        repeat (3) step();
        i_rst = 1'b0;

        // Idle after reset: dark display, with a frame pulse every 32 cycles
        f0 = n_frame;
        repeat (64) step();
        check("idle_frames", n_frame - f0, 2);
        check("idle_dark", n_lit, 0);

        // A single load is acked once and then displayed in the next frame
        i_blink = 8'h01;
        a0 = n_ack;
        do_load(32'h76543210, 8'h00, 8'h01);
        repeat (64) step();
        check("load_single_ack", n_ack - a0, 1);
        check("load_dig0_seg", seen_seg[0], 7'h3F);
        check("load_dig5_seg", seen_seg[5], 7'h6D);

        // Two loads in one frame: only one ack, and the later load wins
        to_frame_start();
        a0 = n_ack;
        do_load(32'h12345678, 8'h00, 8'h00);
        repeat (3) step();
        do_load(32'h9ABCDEF0, 8'h00, 8'h80);
        repeat (64) step();
        check("b2b_single_ack", n_ack - a0, 1);
        check("b2b_dig0_seg", seen_seg[0], 7'h3F);
        check("b2b_dig7_seg", seen_seg[7], 7'h6F);

        // Load in the wrap cycle while nothing is pending: ack one frame later
        for (int i = 0; i < FRAME && (m_c % FRAME) != FRAME - 1; i++) step();
        a0 = n_ack;
        do_load($urandom, 8'h00, 8'($urandom));
        check("wrap_load_no_ack", n_ack - a0, 0);
        repeat (FRAME) step();
        check("wrap_load_late_ack", n_ack - a0, 1);

        // Upper digits blanked: no enable ever reaches 10..80
        do_load($urandom, 8'hF0, 8'hFF);
        repeat (FRAME) step();
        n_hi = 0;
        repeat (2 * FRAME) step();
        check("blank_hi_dark", n_hi, 0);

        // Reset mid-frame: outputs clear and the pending load is discarded
        to_frame_start();
        repeat (5) step();
        do_load($urandom, 8'h00, 8'hFF);
        repeat (4) step();
        i_rst = 1'b1;
        step();
        check("rst_outputs", {o_an, o_seg, o_dp, o_load_ack, o_frame}, 18'd0);
        i_rst = 1'b0;
        n_lit = 0; a0 = n_ack;
        repeat (2 * FRAME) step();
        check("rst_load_lost_dark", n_lit, 0);
        check("rst_load_lost_ack", n_ack - a0, 0);

        // Random loads at random times, with random masks and blink bits
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 40)) step();
            i_blink = 8'($urandom);
            do_load($urandom, 8'($urandom), 8'($urandom));
        end
        repeat (3 * FRAME) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Multiplexed 8-digit seven-segment display driver for the vending machine UI.
- It is the output side of the front panel; the keypad scanner is the input side.
- Takes hex digit values, blank and decimal-point masks from the control logic and time-multiplexes them onto a common anode/segment bus.
- Updates are double-buffered and applied only at a frame boundary, so a new value never shows on some digits and not others.

Parameters:
- SCAN_DIV, 100000, i_clk cycles per digit slot (1 ms at 100 MHz); legal range 2 or more.
- BLINK_DIV, 250, number of frames per blink phase; used only with SEG_BLINK_EN.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  synchronous, active-high reset.
- i_load  input  1  one-cycle strobe; captures i_digits/i_blank/i_dp into the pending buffer.
- i_digits  input  32  eight 4-bit hex values; digit k is bits [4k+3:4k].
- i_blank  input  8  per-digit blank mask; 1 = digit dark.
- i_dp  input  8  per-digit decimal point; 1 = lit.
- i_blink  input  8  per-digit blink mask; ignored without SEG_BLINK_EN.
- o_an  output  8  digit enables, active-high, one-hot or all-zero.
- o_seg  output  7  segments {g,f,e,d,c,b,a}, active-high.
- o_dp  output  1  decimal point, active-high.
- o_load_ack  output  1  one-cycle pulse when a pending load is applied to the display.
- o_frame  output  1  one-cycle pulse when the scan wraps to digit 0.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset values:
  - prescaler = 0, digit index = 0, pending_valid = 0.
  - Active display buffer: digits 0, blank mask 8'hFF, dp 0.
  - Pending buffer: 0. Blink phase = 0, frame counter = 0.
  - o_an = 0, o_seg = 0, o_dp = 0, o_load_ack = 0, o_frame = 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - tick = (prescaler == SCAN_DIV-1).
- Digit index (3 bits):
  - Increments on tick; wraps 7 -> 0.
  - wrap = tick && index == 7.
- Frame boundary (wrap cycle):
  - o_frame = 1 on the next cycle.
  - If pending_valid: active <= pending, pending_valid <= 0, o_load_ack = 1 on the next cycle.
- Load capture:
  - i_load = 1 writes the pending buffer and sets pending_valid, in any cycle.
  - Back-to-back loads before a frame boundary: the latest wins, with a single ack.
- i_load in the same cycle as wrap:
  - The apply uses the old pending contents, and ack fires only if the old pending was valid.
  - The new data is captured and applied at the following frame.
- Output stage, registered, 1 cycle after the index changes:
  - o_an = 1 << index, or 0 if the selected digit is blanked.
  - o_seg = decode(active digit), or 0 if blanked.
  - o_dp = dp bit AND not blanked.
- Decode table, {g..a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Reset mid-frame: everything returns to reset values on the next edge, and the pending load is discarded.
- One full frame = 8*SCAN_DIV cycles.

Optional Feature:
- Macro: SEG_BLINK_EN.
- With the macro:
  - A frame counter counts wraps 0..BLINK_DIV-1.
  - On reaching the terminal count it toggles the blink phase.
  - While phase = 1, digits with their i_blink bit set are treated as blanked. i_blink is sampled live, not buffered.
- Without the macro:
  - i_blink is ignored.
  - No frame counter or phase register is synthesised.
  - Blanking depends only on the active blank mask.

Test Plan:
- Reset then idle, SCAN_DIV=4 -> o_an/o_seg/o_dp stay 0 for 64 cycles; o_frame pulses every 32 cycles.
- i_load with i_digits=32'h76543210, i_blank=0, i_dp=8'h01 -> o_load_ack pulses once at the next wrap. Following frame: o_an cycles 01,02,...,80 every 4 cycles; o_seg = 3F,06,5B,4F,66,6D,7D,07; o_dp=1 only while o_an=01.
- Two loads (12345678, then 9ABCDEF0) within one frame -> a single ack; the display shows 9ABCDEF0 (digit0 seg=3F, digit7 seg=6F).
- i_load coincident with the wrap cycle while pending is empty -> no ack at that wrap; ack and the new data at the next wrap.
- i_blank=8'hF0 -> o_an never asserts 10..80 and o_seg = 0 during those slots; an i_rst pulse mid-frame -> outputs 0 the next cycle and the earlier load is lost.
- SEG_BLINK_EN, BLINK_DIV=2, i_blink=8'h01 -> digit 0 is lit for 2 frames and dark for 2 frames, repeating. Without the macro, digit 0 is always lit.
